// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, FSM states, frame result encoding and key map
// for the 4x4 keypad scanner (optional auto-repeat: KEYPAD_AUTOREPEAT_EN).
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;
  localparam logic [3:0] KEY_CLEAR = 4'hD;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} key_state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_e;

  // Legend of the key at matrix position pos = {col, row}
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'h0: code = KEY_1;
      4'h1: code = KEY_4;
      4'h2: code = KEY_7;
      4'h3: code = KEY_STAR;
      4'h4: code = KEY_2;
      4'h5: code = KEY_5;
      4'h6: code = KEY_8;
      4'h7: code = KEY_0;
      4'h8: code = KEY_3;
      4'h9: code = KEY_6;
      4'hA: code = KEY_9;
      4'hB: code = KEY_HASH;
      4'hC: code = KEY_A;
      4'hD: code = KEY_B;
      4'hE: code = KEY_C;
      4'hF: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_scan_tick_gen.sv
// scan_tick_gen: prescaler emitting a 1-cycle tick every CLK_HZ/SCAN_HZ cycles.
module scan_tick_gen #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV  = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // free-running divider, wraps on the tick cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix scanner with frame-based debounce.
// Optional auto-repeat of valid when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned SCAN_HZ         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 8,
  parameter int unsigned DUR_W           = 16
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 500
  , parameter int unsigned REPEAT_RATE   = 100
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic [3:0]       key_code,
  output logic             valid,
  output logic [DUR_W-1:0] press_duration
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DB_N = CNT_W'(DEBOUNCE_FRAMES);

  logic             tick;
  logic [3:0]       row_meta, row_sync;
  logic [1:0]       col_q;
  logic [11:0]      hits_q;
  logic [15:0]      frame_hits;
  logic             frame_end;
  logic [4:0]       n_hits;
  logic [3:0]       frame_code;
  logic             cand_seen;
  frame_res_e       frame_res;

  key_state_e       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [DUR_W-1:0] dur_q, dur_d;

  scan_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // two-stage synchronizer; idle rows read high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // sample the driven column on each tick, then step to the next column
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      hits_q <= '0;
    end else if (tick) begin
      col_q <= col_q + 1'b1;
      case (col_q)
        2'd0:    hits_q[3:0]  <= ~row_sync;
        2'd1:    hits_q[7:4]  <= ~row_sync;
        2'd2:    hits_q[11:8] <= ~row_sync;
        default: ;
      endcase
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign frame_end  = tick && (col_q == 2'd3);
  assign frame_hits = {~row_sync, hits_q};

  // classify the completed frame and look for the candidate key in it
  always_comb begin
    n_hits     = '0;
    frame_code = '0;
    cand_seen  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame_hits[i]) begin
        n_hits     = n_hits + 5'd1;
        frame_code = key_map(4'(i));
        if (key_map(4'(i)) == cand_q) cand_seen = 1'b1;
      end
    end
    frame_res = (n_hits == 5'd0) ? NONE : (n_hits == 5'd1) ? SINGLE : MULTI;
  end

  // debounce FSM, advanced only at frame end
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    dur_d   = dur_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (frame_end) begin
      if ((state_q == PRESSED || state_q == RELEASE) && dur_q != '1)
        dur_d = dur_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (frame_res == SINGLE) begin
            state_d = DEBOUNCE;
            cand_d  = frame_code;
            cnt_d   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (frame_res == SINGLE && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_N) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              dur_d   = '0;
            end
          end else if (frame_res == SINGLE) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (!cand_seen) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cand_seen) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_N) begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      dur_q   <= dur_d;
    end
  end

  assign key_code       = code_q;
  assign press_duration = dur_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [DUR_W-1:0] RPT_DLY  = DUR_W'(REPEAT_DELAY);
  localparam logic [DUR_W-1:0] RPT_LAST = DUR_W'(REPEAT_RATE - 1);

  logic [DUR_W-1:0] rpt_q;
  logic             rpt_gap;

  // phase within the repeat period; phase 0 is the one-frame low gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      rpt_q <= '0;
    else if (state_d != PRESSED || dur_d < RPT_DLY) rpt_q <= '0;
    else if (frame_end)
      rpt_q <= (dur_d == RPT_DLY || rpt_q == RPT_LAST) ? '0 : rpt_q + 1'b1;
  end

  assign rpt_gap = (state_q == PRESSED) && (dur_q >= RPT_DLY) && (rpt_q == '0);
  assign valid   = valid_q & ~rpt_gap;
`else
  assign valid = valid_q;
`endif

endmodule
